// File: rtl/apb_bridge_controller.sv
// AHB-to-APB bridge sequencing FSM: one APB SETUP/ACCESS per accepted AHB
// transfer, AHB stall via hready_out, and a pready watchdog.
module apb_bridge_controller #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NSEL     = 3,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [NSEL-1:0]   temp_selx,
  input  logic              pready,
  output logic              hready_out,
  output logic [NSEL-1:0]   pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              timeout_err
);

  localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  typedef enum logic [1:0] {IDLE, WWAIT, SETUP, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [NSEL-1:0]   sel_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0]     wcnt_q;
  logic              timeout_err_q;

  logic accept, timeout_hit;
  logic load_req, cap_wdata, clr_cnt, inc_cnt, set_to;

  assign accept      = valid && (temp_selx != '0);
  // Depends only on registered state, so the watchdog adds no input path.
  assign timeout_hit = (MAX_WAIT != 0) && (state_q == ACCESS) && (wcnt_q == LAST);

  always_comb begin
    state_d    = state_q;
    hready_out = 1'b1;
    load_req   = 1'b0;
    cap_wdata  = 1'b0;
    clr_cnt    = 1'b0;
    inc_cnt    = 1'b0;
    set_to     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          load_req = 1'b1;
          state_d  = hwrite ? WWAIT : SETUP;
        end
      end
      WWAIT: begin
        hready_out = 1'b0;
        cap_wdata  = 1'b1;
        state_d    = SETUP;
      end
      SETUP: begin
        hready_out = 1'b0;
        clr_cnt    = 1'b1;
        state_d    = ACCESS;
      end
      ACCESS: begin
        hready_out = pready || timeout_hit;
        if (pready || timeout_hit) begin
          set_to = timeout_hit && !pready;
          if (accept) begin
            load_req = 1'b1;
            state_d  = hwrite ? WWAIT : SETUP;
          end else begin
            state_d = IDLE;
          end
        end else begin
          inc_cnt = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wr_q          <= 1'b0;
      sel_q         <= '0;
      wdata_q       <= '0;
      wcnt_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_req) begin
        addr_q <= haddr;
        wr_q   <= hwrite;
        sel_q  <= temp_selx;
      end
      if (cap_wdata) wdata_q <= hwdata;
      if (clr_cnt) wcnt_q <= '0;
      else if (inc_cnt && (wcnt_q != '1)) wcnt_q <= wcnt_q + 1'b1;
      if (set_to) timeout_err_q <= 1'b1;
    end
  end

  assign pselx       = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : '0;
  assign penable     = (state_q == ACCESS);
  assign pwrite      = wr_q;
  assign paddr       = addr_q;
  assign pwdata      = wdata_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_apb_bridge_controller.sv
// Directed bench for apb_bridge_controller: default instance plus a
// MAX_WAIT=4 instance sharing the same stimulus for the watchdog cases.
module tb_apb_bridge_controller;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        valid, hwrite, pready;
  logic [31:0] haddr, hwdata;
  logic [2:0]  temp_selx;

  logic        hready_a, penable_a, pwrite_a, terr_a;
  logic [2:0]  pselx_a;
  logic [31:0] paddr_a, pwdata_a;
  logic        hready_b, penable_b, pwrite_b, terr_b;
  logic [2:0]  pselx_b;
  logic [31:0] paddr_b, pwdata_b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 hclk = ~hclk;

  apb_bridge_controller dut (
    .hclk(hclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite),
    .haddr(haddr), .hwdata(hwdata), .temp_selx(temp_selx), .pready(pready),
    .hready_out(hready_a), .pselx(pselx_a), .penable(penable_a),
    .pwrite(pwrite_a), .paddr(paddr_a), .pwdata(pwdata_a),
    .timeout_err(terr_a)
  );

  apb_bridge_controller #(.MAX_WAIT(4)) dut_to (
    .hclk(hclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite),
    .haddr(haddr), .hwdata(hwdata), .temp_selx(temp_selx), .pready(pready),
    .hready_out(hready_b), .pselx(pselx_b), .penable(penable_b),
    .pwrite(pwrite_b), .paddr(paddr_b), .pwdata(pwdata_b),
    .timeout_err(terr_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 1'b0; hwrite = 1'b0; haddr = '0; temp_selx = '0;
  endtask

  initial begin
    hresetn = 1'b0; pready = 1'b1; hwdata = '0;
    idle_inputs();
    #2;
    check("rst_hready", {31'b0, hready_a}, 32'd1);
    check("rst_pselx", {29'b0, pselx_a}, 32'd0);
    check("rst_penable", {31'b0, penable_a}, 32'd0);
    check("rst_pwrite", {31'b0, pwrite_a}, 32'd0);
    check("rst_paddr", paddr_a, 32'd0);
    check("rst_pwdata", pwdata_a, 32'd0);
    check("rst_terr", {31'b0, terr_a}, 32'd0);
    tick(); tick();
    hresetn = 1'b1;
    tick();

    // Read, pready=1
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h10; temp_selx = 3'b001; #1;
    check("rd_idle_hready", {31'b0, hready_a}, 32'd1);
    tick(); idle_inputs(); #1;
    check("rd_setup_psel", {29'b0, pselx_a}, 32'd1);
    check("rd_setup_pen", {31'b0, penable_a}, 32'd0);
    check("rd_setup_paddr", paddr_a, 32'h10);
    check("rd_setup_hready", {31'b0, hready_a}, 32'd0);
    check("rd_setup_pwrite", {31'b0, pwrite_a}, 32'd0);
    tick(); #1;
    check("rd_acc_pen", {31'b0, penable_a}, 32'd1);
    check("rd_acc_psel", {29'b0, pselx_a}, 32'd1);
    check("rd_acc_hready", {31'b0, hready_a}, 32'd1);
    tick(); #1;
    check("rd_idle_psel", {29'b0, pselx_a}, 32'd0);
    check("rd_idle_hready2", {31'b0, hready_a}, 32'd1);

    // Write, pready=1
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0004; temp_selx = 3'b010;
    tick(); idle_inputs(); hwdata = 32'hDEAD_BEEF; #1;
    check("wr_wwait_hready", {31'b0, hready_a}, 32'd0);
    check("wr_wwait_psel", {29'b0, pselx_a}, 32'd0);
    tick(); hwdata = 32'h0; #1;
    check("wr_setup_pwdata", pwdata_a, 32'hDEAD_BEEF);
    check("wr_setup_pwrite", {31'b0, pwrite_a}, 32'd1);
    check("wr_setup_psel", {29'b0, pselx_a}, 32'd2);
    check("wr_setup_paddr", paddr_a, 32'h8400_0004);
    check("wr_setup_hready", {31'b0, hready_a}, 32'd0);
    tick(); #1;
    check("wr_acc_pen", {31'b0, penable_a}, 32'd1);
    check("wr_acc_hready", {31'b0, hready_a}, 32'd1);
    tick(); #1;
    check("wr_done_pen", {31'b0, penable_a}, 32'd0);

    // Back-to-back: write then read in the completing ACCESS cycle
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h20; temp_selx = 3'b001;
    tick(); idle_inputs(); hwdata = 32'h1234_5678;
    tick(); tick();
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h24; temp_selx = 3'b001; #1;
    check("b2b_acc_pen", {31'b0, penable_a}, 32'd1);
    check("b2b_acc_hready", {31'b0, hready_a}, 32'd1);
    check("b2b_acc_pwdata", pwdata_a, 32'h1234_5678);
    tick(); idle_inputs(); #1;
    check("b2b_setup_psel", {29'b0, pselx_a}, 32'd1);
    check("b2b_setup_pen", {31'b0, penable_a}, 32'd0);
    check("b2b_setup_paddr", paddr_a, 32'h24);
    check("b2b_setup_pwrite", {31'b0, pwrite_a}, 32'd0);
    tick(); tick(); #1;
    check("b2b_idle_psel", {29'b0, pselx_a}, 32'd0);

    // Wait states: 3 ACCESS cycles with pready low
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h30; temp_selx = 3'b100;
    tick(); idle_inputs(); pready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ws_hready", {31'b0, hready_a}, 32'd0);
      check("ws_paddr", paddr_a, 32'h30);
      check("ws_psel", {29'b0, pselx_a}, 32'd4);
      tick();
    end
    pready = 1'b1; #1;
    check("ws_done_hready", {31'b0, hready_a}, 32'd1);
    check("ws_to4_hready", {31'b0, hready_b}, 32'd1);
    tick(); #1;
    check("ws_terr", {31'b0, terr_a}, 32'd0);
    check("ws_terr_to4", {31'b0, terr_b}, 32'd0);
    check("ws_idle_psel", {29'b0, pselx_a}, 32'd0);

    // Timeout on the MAX_WAIT=4 instance
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h40; temp_selx = 3'b001;
    tick(); idle_inputs(); pready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("to_wait_hready", {31'b0, hready_b}, 32'd0);
      tick();
    end
    #1;
    check("to_forced_hready", {31'b0, hready_b}, 32'd1);
    check("to_forced_default_hready", {31'b0, hready_a}, 32'd0);
    check("to_terr_before", {31'b0, terr_b}, 32'd0);
    tick(); #1;
    check("to_terr_set", {31'b0, terr_b}, 32'd1);
    check("to_idle_psel", {29'b0, pselx_b}, 32'd0);
    check("to_idle_pen", {31'b0, penable_b}, 32'd0);
    check("to_default_terr", {31'b0, terr_a}, 32'd0);
    pready = 1'b1;
    tick(); #1;
    check("to_default_done_psel", {29'b0, pselx_a}, 32'd0);

    // Unmapped transfer
    valid = 1'b1; hwrite = 1'b1; haddr = 32'h5000; temp_selx = 3'b000; #1;
    check("um_hready", {31'b0, hready_a}, 32'd1);
    tick(); #1;
    check("um_psel", {29'b0, pselx_a}, 32'd0);
    check("um_hready2", {31'b0, hready_a}, 32'd1);
    idle_inputs();
    tick(); #1;
    check("um_psel2", {29'b0, pselx_a}, 32'd0);
    check("to_terr_sticky", {31'b0, terr_b}, 32'd1);

    // Reset asserted in ACCESS
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h60; temp_selx = 3'b010;
    tick(); idle_inputs(); pready = 1'b0;
    tick(); #1;
    check("ra_pen_pre", {31'b0, penable_a}, 32'd1);
    #1 hresetn = 1'b0; #1;
    check("ra_psel", {29'b0, pselx_a}, 32'd0);
    check("ra_pen", {31'b0, penable_a}, 32'd0);
    check("ra_hready", {31'b0, hready_a}, 32'd1);
    check("ra_terr_cleared", {31'b0, terr_b}, 32'd0);
    @(negedge hclk);
    hresetn = 1'b1; pready = 1'b1;
    tick(); #1;
    check("ra_idle_psel", {29'b0, pselx_a}, 32'd0);
    check("ra_idle_hready", {31'b0, hready_a}, 32'd1);
    valid = 1'b1; hwrite = 1'b0; haddr = 32'h70; temp_selx = 3'b100;
    tick(); idle_inputs(); #1;
    check("ra_new_setup_psel", {29'b0, pselx_a}, 32'd4);
    check("ra_new_setup_paddr", paddr_a, 32'h70);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
